clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Parametrised, reconfigurable clock-enable generator for the system clock domain. It derives NUM_CH independent, phase-aligned clock-enable strobes from one reference clock using runtime-programmable integer divisors, and reports a `locked` status once the configuration has been stable for a programmable settling time. It replaces fixed-ratio clock wrappers wherever fabric logic needs slower rates (sample, display, SPI, UART ticks) without adding clock domains.

## Interface
- NUM_CH, 3, number of enable channels (1..16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset
- LOCK_CYCLES, 1024, stable cycles required before `locked` asserts (>=1)
- refclk  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  block can accept a write
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel index
- cfg_div  in  DIV_W  new divisor
- ce  out  NUM_CH  per-channel one-cycle enable strobes, registered
- locked  out  1  configuration settled
- outclk  out  NUM_CH  square-wave outputs (only with CLKGEN_SQUARE_EN)

## Operation
- Per channel c: divisor register D[c] and counter cnt[c] (DIV_W bits), counting 0..D[c]-1 and wrapping to 0.
- ce[c] is high exactly in cycles where cnt[c] == D[c]-1. A divisor of 0 is treated as 1. D=1 gives ce[c] high every cycle.
- Reset: all cnt = 0, all D = DEFAULT_DIV, ce = 0, locked = 0, cfg_ready = 1, pending slot empty.
- Handshake: a write is accepted in a cycle where cfg_valid && cfg_ready. An accepted write fills the single pending slot (ch, div), and cfg_ready = 0 while the slot is full. cfg_valid may be held; the source keeps cfg_ch/cfg_div stable until accepted.
- Glitch-free apply: the pending divisor loads into D[ch] in the cycle that channel's ce fires (terminal count). The counter restarts at 0 under the new divisor. The slot then empties, and cfg_ready returns to 1 the next cycle. Apply latency is at most the old D[ch] cycles.
- Out-of-range cfg_ch (>= NUM_CH): the write is accepted, then discarded the next cycle. D and locked are unaffected.
- Lock counter:
  - Clears on reset and on every accepted in-range write.
  - Counts while the pending slot is empty, saturating at LOCK_CYCLES.
  - locked = 1 when the counter equals LOCK_CYCLES.
  - locked drops in the cycle after an in-range write is accepted.
- rst asserted mid-operation discards any pending write and returns every output to its reset value on the next edge.

## Timing
- Cycle 0 is the first cycle with rst low. Channel c with divisor D fires ce in cycles D-1, 2D-1, ….
- All channels share cycle 0, so channels whose divisors share factors have coincident strobes.
- Write accepted in cycle a: cfg_ready is low from a+1. The new divisor applies at the first terminal count t >= a+1. cfg_ready is high again at t+1.
- After reset, locked rises in cycle LOCK_CYCLES-1 (no writes).
- Simultaneous write acceptance and terminal count on the same channel: the new divisor takes effect at the next terminal count, not the current one.

## Configuration
- CLKGEN_SQUARE_EN defined:
  - Adds the `outclk` port.
  - outclk[c] is a registered square wave, high while cnt[c] < D/2 (floor) and low otherwise.
  - For D < 2, outclk[c] is held 0.
  - Reset value is 0.
- CLKGEN_SQUARE_EN undefined: the `outclk` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package clkgen_pkg holds:
  - MAX_CH = 16
  - the clog2 channel-index width function
  - the typedef for the pending-write record {ch, div}
- One sub-module, clkgen_channel: a single divisor/counter/strobe/square-wave slice, instantiated NUM_CH times via generate.
- The top level owns the handshake, the pending slot and the lock counter.

## Test plan
- Reset, defaults (NUM_CH=3, DEFAULT_DIV=2, LOCK_CYCLES=16) -> all ce pulse in cycles 1, 3, 5…; locked rises in cycle 15.
- Write ch1 div=5 in cycle 20 -> locked low in cycle 21; ch1 applies at its next terminal count, then ce[1] has period 5; ch0/ch2 are unchanged; locked rises 16 cycles after the slot empties.
- Back-to-back writes with cfg_valid held -> second write is accepted only after cfg_ready returns; ce never shows a shortened period.
- Divisor 0 and 1 on ch2 -> ce[2] is constant high from the apply cycle; outclk[2] is held 0 (macro on).
- cfg_ch=3 with NUM_CH=3 -> write is accepted; no D changes; locked stays 1.
- rst pulsed with a pending write -> pending write is discarded; outputs return to reset values on the next edge; restart from cycle 0 matches the first scenario.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Optional square-wave outputs are enabled with CLKGEN_SQUARE_EN.
package clkgen_pkg;

   localparam int MAX_CH    = 16;
   localparam int MAX_DIV_W = 32;
   localparam int PEND_CH_W = $clog2(MAX_CH);

   // Channel-index width, never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [PEND_CH_W-1:0] ch;
      logic [MAX_DIV_W-1:0] div;
   } pend_wr_t;

endpackage

// File: rtl/clkgen_channel.sv
// One divisor/counter/strobe slice; loads a new divisor only at its own terminal count.
// Square-wave output present only when CLKGEN_SQUARE_EN is defined.
module clkgen_channel #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_req,
   input  logic [DIV_W-1:0] load_div,
   output logic             applied,
   output logic             ce
`ifdef CLKGEN_SQUARE_EN
   ,
   output logic             outclk
`endif
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] eff_q, eff_d;
   logic             term;
   logic             ce_q, ce_d;
`ifdef CLKGEN_SQUARE_EN
   logic             sq_q, sq_d;
`endif

   always_comb begin
      // A divisor of zero behaves exactly like a divisor of one.
      eff_q   = (div_q == '0) ? DIV_W'(1) : div_q;
      term    = (cnt_q == eff_q - DIV_W'(1));
      applied = load_req && term;
      div_d   = applied ? load_div : div_q;
      cnt_d   = term ? '0 : cnt_q + DIV_W'(1);
      eff_d   = (div_d == '0) ? DIV_W'(1) : div_d;
      ce_d    = (cnt_d == eff_d - DIV_W'(1));
`ifdef CLKGEN_SQUARE_EN
      sq_d    = (eff_d >= DIV_W'(2)) && (cnt_d < (eff_d >> 1));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DIV_W'(DEFAULT_DIV);
         cnt_q <= '0;
         ce_q  <= 1'b0;
`ifdef CLKGEN_SQUARE_EN
         sq_q  <= 1'b0;
`endif
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
         ce_q  <= ce_d;
`ifdef CLKGEN_SQUARE_EN
         sq_q  <= sq_d;
`endif
      end
   end

   assign ce = ce_q;
`ifdef CLKGEN_SQUARE_EN
   assign outclk = sq_q;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// Reconfigurable multi-channel clock-enable generator with a single pending-write slot
// and settle-time lock status. Define CLKGEN_SQUARE_EN to add the outclk square waves.
module clk_enable_gen
   import clkgen_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 1024
) (
   input  logic                        refclk,
   input  logic                        rst,
   // valid/ready: a write transfers in any cycle where cfg_valid && cfg_ready; the
   // source holds cfg_ch/cfg_div stable until then, and cfg_ready never waits on cfg_valid.
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
   input  logic [DIV_W-1:0]            cfg_div,
   output logic [NUM_CH-1:0]           ce,
   output logic                        locked
`ifdef CLKGEN_SQUARE_EN
   ,
   output logic [NUM_CH-1:0]           outclk
`endif
);

   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [LOCK_W-1:0] LOCK_SAT = LOCK_W'(LOCK_CYCLES - 1);

   pend_wr_t          pend_q, pend_d;
   logic              pend_valid_q, pend_valid_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;
   logic              accept, cfg_in_range, pend_in_range;
   logic [NUM_CH-1:0] load_req, applied;
   logic [DIV_W-1:0]  load_div;
   logic              pend_unused;

   assign cfg_ready     = !pend_valid_q;
   assign accept        = cfg_valid && cfg_ready;
   assign cfg_in_range  = (int'(cfg_ch) < NUM_CH);
   assign pend_in_range = (int'(pend_q.ch) < NUM_CH);
   assign load_div      = DIV_W'(pend_q.div);
   assign pend_unused   = ^pend_q;

   always_comb begin
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_d.ch    = PEND_CH_W'(cfg_ch);
         pend_d.div   = MAX_DIV_W'(cfg_div);
      end else if (pend_valid_q && ((|applied) || !pend_in_range)) begin
         // Out-of-range writes are dropped after one cycle in the slot.
         pend_valid_d = 1'b0;
      end
   end

   // The lock count is the number of settled cycles up to and including this one.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (accept && cfg_in_range) begin
         lock_cnt_d = '0;
      end else if (!pend_valid_q && (lock_cnt_q != LOCK_SAT)) begin
         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
      locked_d = !(accept && cfg_in_range) && (lock_cnt_d == LOCK_SAT);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         lock_cnt_q   <= lock_cnt_d;
         locked_q     <= locked_d;
      end
   end

   assign locked = locked_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign load_req[g] = pend_valid_q && (pend_q.ch == PEND_CH_W'(g));

      clkgen_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk      (refclk),
         .rst      (rst),
         .load_req (load_req[g]),
         .load_div (load_div),
         .applied  (applied[g]),
         .ce       (ce[g])
`ifdef CLKGEN_SQUARE_EN
         ,
         .outclk   (outclk[g])
`endif
      );
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed and randomised stimulus for clk_enable_gen against a cycle-level timing model.
module tb_clk_enable_gen;

   localparam int NUM_CH      = 3;
   localparam int DIV_W       = 16;
   localparam int DEFAULT_DIV = 2;
   localparam int LOCK_CYCLES = 16;
   localparam int EW          = 2 * NUM_CH + 2;

   logic              refclk    = 1'b0;
   logic              rst       = 1'b1;
   logic              cfg_valid = 1'b0;
   logic [1:0]        cfg_ch    = '0;
   logic [DIV_W-1:0]  cfg_div   = '0;
   logic              cfg_ready;
   logic [NUM_CH-1:0] ce;
   logic              locked;
`ifdef CLKGEN_SQUARE_EN
   logic [NUM_CH-1:0] outclk;
`endif

   always #5 refclk = ~refclk;

   clk_enable_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .ce        (ce),
      .locked    (locked)
`ifdef CLKGEN_SQUARE_EN
      ,
      .outclk    (outclk)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc;

   // Model: each channel's divisor and the cycle of its next strobe.
   int div_m[NUM_CH];
   int next_fire[NUM_CH];
   bit pend_v;
   int pend_ch;
   int pend_div;
   int emp;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] expected_now();
      logic [NUM_CH-1:0] ce_e, oc_e;
      int ph;
      for (int c = 0; c < NUM_CH; c++) begin
         ce_e[c] = (cyc == next_fire[c]);
         ph      = div_m[c] - 1 - (next_fire[c] - cyc);
         oc_e[c] = (cyc != 0) && (div_m[c] >= 2) && (ph < div_m[c] / 2);
      end
      return {oc_e, ce_e, !pend_v, (emp >= LOCK_CYCLES - 1)};
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         div_m[c]     = (DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV;
         next_fire[c] = div_m[c] - 1;
      end
      pend_v = 1'b0;
      emp    = 0;
      exp_q.delete();
      exp_q.push_back(expected_now());
   endtask

   // Compare this cycle's outputs, advance the model, then clock the DUT.
   task automatic tick();
      logic [EW-1:0] e;
      bit rdy_now, acc, app;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty cyc=%0d", cyc);
      end else begin
         e = exp_q.pop_front();
         check("ce", 32'(ce), 32'(e[NUM_CH+1:2]));
         check("cfg_ready", 32'(cfg_ready), 32'(e[1]));
         check("locked", 32'(locked), 32'(e[0]));
`ifdef CLKGEN_SQUARE_EN
         check("outclk", 32'(outclk), 32'(e[EW-1:NUM_CH+2]));
`endif
      end
      rdy_now = !pend_v;
      acc     = cfg_valid && rdy_now;
      app     = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cyc == next_fire[c]) begin
            if (pend_v && pend_ch == c) begin
               div_m[c] = (pend_div == 0) ? 1 : pend_div;
               app      = 1'b1;
            end
            next_fire[c] = cyc + div_m[c];
         end
      end
      if (pend_v && (app || pend_ch >= NUM_CH)) pend_v = 1'b0;
      if (acc) begin
         pend_v   = 1'b1;
         pend_ch  = int'(cfg_ch);
         pend_div = int'(cfg_div);
      end
      if (acc && int'(cfg_ch) < NUM_CH) emp = 0;
      else if (rdy_now) emp++;
      cyc++;
      exp_q.push_back(expected_now());
      @(posedge refclk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input int ch, input int div);
      cfg_ch    = 2'(ch);
      cfg_div   = DIV_W'(div);
      cfg_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (cfg_ready) begin
            tick();
            cfg_valid = 1'b0;
            return;
         end
         tick();
      end
      cfg_valid = 1'b0;
      checks++;
      failures++;
      $display("FAIL send_timeout ch=%0d div=%0d cfg_ready=%0b required=1", ch, div, cfg_ready);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge refclk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge refclk);
      #1;
      rst = 1'b0;
      model_reset();

      run(20);
      send(1, 5);
      run(40);

      send(0, 3);
      send(0, 4);
      run(30);

      send(2, 0);
      run(10);
      send(2, 1);
      run(10);

      run(40);
      send(3, 7);
      run(10);

      send(1, 9);
      do_reset();
      run(20);

      for (int k = 0; k < 6; k++) begin
         send($urandom_range(0, NUM_CH - 1), $urandom_range(1, 6));
         run($urandom_range(0, 8));
      end
      run(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
